// File: rtl/spi_target.sv
// SPI mode-0 target on the iomem bus: oversampled pins, RX FIFO, TX holding register, sticky flags.
// Define SPI_TARGET_IRQ_EN to add the irq output and the interrupt-enable register at reg 3.
module spi_target #(
   parameter int         RX_DEPTH  = 4,
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe
`ifdef SPI_TARGET_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int          AW        = $clog2(RX_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(RX_DEPTH);

   // Pin synchronisers; index 2 is the extra flop used only for edge detection
   logic [2:0] sck_sync;
   logic [2:0] cs_sync;
   logic [1:0] mosi_sync;

   logic sck_rise;
   logic sck_fall;
   logic cs_fall;
   logic selected;
   logic mosi_s;

   logic [2:0]    bit_cnt;
   logic [7:0]    rx_sh;
   logic [7:0]    tx_sh;
   logic [7:0]    hold;
   logic          hold_full;
   logic          ovr;
   logic          unr;
   logic          txo;

   logic [7:0]    mem [RX_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          rx_valid;
   logic          rx_full;
   logic          byte_done;
   logic          tx_load;
   logic          consume;
   logic          push;
   logic          pop;
   logic          hold_avail;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_next;

   logic          access;
   logic          is_write;
   logic          is_read;
   logic [1:0]    reg_sel;
   logic          data_wr;
   logic          data_rd;
   logic          stat_wr;
   logic [2:0]    flag_clr;
   logic [31:0]   rd_word;

`ifdef SPI_TARGET_IRQ_EN
   logic [2:0]    ie;
`endif

   logic          unused_bits;
   assign unused_bits = &{1'b0, iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:8], iomem_wdata[3]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sync  <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sck_sync  <= {sck_sync[1:0], spi_sck};
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
      end
   end

   assign sck_rise = sck_sync[1] & ~sck_sync[2];
   assign sck_fall = ~sck_sync[1] & sck_sync[2];
   assign cs_fall  = ~cs_sync[1] & cs_sync[2];
   assign selected = ~cs_sync[1];
   assign mosi_s   = mosi_sync[1];

   assign spi_miso    = tx_sh[7];
   assign spi_miso_oe = selected;

   // Bus decode: an access is the single cycle where valid is seen without ready
   assign access   = iomem_valid && !iomem_ready;
   assign is_write = access && (|iomem_wstrb);
   assign is_read  = access && !(|iomem_wstrb);
   assign reg_sel  = iomem_addr[3:2];
   assign data_wr  = is_write && (reg_sel == 2'd0);
   assign data_rd  = is_read && (reg_sel == 2'd0);
   assign stat_wr  = is_write && (reg_sel == 2'd1);
   assign flag_clr = stat_wr ? iomem_wdata[6:4] : 3'b000;

   assign rx_valid = (count != '0);
   assign rx_full  = (count == DEPTH_CNT);
   assign pop      = data_rd && rx_valid;

   // Byte boundary (8th selected rise) and CS fall both reload the transmit shifter
   assign byte_done = selected && !cs_fall && sck_rise && (bit_cnt == 3'd7);
   assign tx_load   = cs_fall || byte_done;
   assign consume   = tx_load && hold_full;
   assign tx_next   = hold_full ? hold : IDLE_BYTE;
   assign rx_byte   = {rx_sh[6:0], mosi_s};

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
   assign push       = byte_done && (!rx_full || pop);
   // A consume in the same cycle empties HOLD before the CPU write lands
   assign hold_avail = !hold_full || consume;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= 3'd0;
         rx_sh   <= 8'd0;
         tx_sh   <= 8'd0;
      end else if (!selected) begin
         bit_cnt <= 3'd0;
      end else if (cs_fall) begin
         bit_cnt <= 3'd0;
         tx_sh   <= tx_next;
      end else if (sck_rise) begin
         rx_sh   <= rx_byte;
         bit_cnt <= bit_cnt + 3'd1;
         if (byte_done) begin
            tx_sh <= tx_next;
         end
      end else if (sck_fall && (bit_cnt != 3'd0)) begin
         tx_sh <= {tx_sh[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold      <= 8'd0;
         hold_full <= 1'b0;
      end else if (data_wr && hold_avail) begin
         hold      <= iomem_wdata[7:0];
         hold_full <= 1'b1;
      end else if (consume) begin
         hold_full <= 1'b0;
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr <= 1'b0;
         unr <= 1'b0;
         txo <= 1'b0;
      end else begin
         ovr <= (byte_done && !push) | (ovr & ~flag_clr[0]);
         unr <= (tx_load && !hold_full) | (unr & ~flag_clr[1]);
         txo <= (data_wr && !hold_avail) | (txo & ~flag_clr[2]);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_byte;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef SPI_TARGET_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie <= 3'b000;
      end else if (is_write && (reg_sel == 2'd3)) begin
         ie <= iomem_wdata[2:0];
      end
   end

   assign irq = (rx_valid & ie[0]) | (!hold_full & ie[1]) | ((ovr | unr | txo) & ie[2]);
`endif

   always_comb begin
      rd_word = 32'd0;
      case (reg_sel)
         2'd0: begin
            if (rx_valid) begin
               rd_word = {23'd0, 1'b1, mem[rd_ptr]};
            end
         end
         2'd1: rd_word = {25'd0, txo, unr, ovr, selected, !hold_full, rx_full, rx_valid};
         2'd2: rd_word = {{(31-AW){1'b0}}, count};
`ifdef SPI_TARGET_IRQ_EN
         2'd3: rd_word = {29'd0, ie};
`else
         2'd3: rd_word = 32'd0;
`endif
         default: rd_word = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'd0;
      end else begin
         iomem_ready <= access;
         iomem_rdata <= is_read ? rd_word : 32'd0;
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: vector table plus scoreboarded multi-cycle sequences.
module tb_spi_target;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        spi_sck = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
`ifdef SPI_TARGET_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   spi_target #(.RX_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe)
`ifdef SPI_TARGET_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   typedef struct packed {
      logic       load;
      logic [7:0] hold;
      logic [7:0] mosi;
      logic [7:0] miso;
   } vec_t;

   vec_t        vecs [6];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  miso_q [$];
   logic [31:0] rx_q [$];
   int          mdl_cnt = 0;
   logic        oe_all;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus_access(input logic wr, input logic [1:0] sel, input logic [31:0] wd,
                             output logic [31:0] rd);
      int n;
      iomem_valid = 1'b1;
      iomem_wstrb = wr ? 4'hF : 4'h0;
      iomem_addr  = {28'h0, sel, 2'b00};
      iomem_wdata = wd;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!iomem_ready && n < 6);
      if (!iomem_ready) begin
         checks++;
         failures++;
         $display("FAIL bus_timeout actual=no_ready required=ready");
      end
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      $display("bus %s reg%0d wdata=%h rdata=%h", wr ? "wr" : "rd", sel, wd, rd);
   endtask

   task automatic bus_wr(input logic [1:0] sel, input logic [31:0] wd);
      logic [31:0] dummy;
      @(negedge clk);
      bus_access(1'b1, sel, wd, dummy);
   endtask

   task automatic bus_rd(input logic [1:0] sel, output logic [31:0] rd);
      @(negedge clk);
      bus_access(1'b0, sel, 32'h0, rd);
   endtask

   task automatic rd_check(input string name, input logic [1:0] sel, input logic [31:0] exp);
      logic [31:0] rd;
      bus_rd(sel, rd);
      check(name, rd, exp);
   endtask

   // Read DATA and compare with the RX scoreboard (0 when the model FIFO is empty)
   task automatic pop_check(input string name);
      logic [31:0] rd;
      logic [31:0] exp;
      bus_rd(2'd0, rd);
      if (rx_q.size() == 0) begin
         exp = 32'h0;
      end else begin
         exp = rx_q.pop_front();
         mdl_cnt--;
      end
      check(name, rd, exp);
   endtask

   task automatic cs_on();
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_off();
      repeat (8) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Host side of nbits mode-0 bits; optionally issues a DATA read landing on the clk the DUT acts on bit pop_bit's rise
   task automatic spi_byte(input logic [7:0] tx, input int nbits, input int pop_bit,
                           output logic [7:0] got, output logic [31:0] popped);
      got    = 8'h00;
      popped = 32'h0;
      oe_all = 1'b1;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_mosi = tx[i];
         repeat (8) @(negedge clk);
         spi_sck = 1'b1;
         got[i]  = spi_miso;
         oe_all  = oe_all & spi_miso_oe;
         if (i == pop_bit) begin
            repeat (2) @(negedge clk);
            bus_access(1'b0, 2'd0, 32'h0, popped);
            repeat (5) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx);
      logic [7:0]  got;
      logic [31:0] pd;
      logic [7:0]  exp;
      spi_byte(tx, 8, -1, got, pd);
      if (miso_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL miso_sb_empty actual=%h required=none", got);
      end else begin
         exp = miso_q.pop_front();
         check("miso", {24'h0, got}, {24'h0, exp});
      end
      check("miso_oe", {31'h0, oe_all}, 32'h1);
      if (mdl_cnt < 4) begin
         rx_q.push_back({23'h0, 1'b1, tx});
         mdl_cnt++;
      end
      $display("spi mosi=%h miso=%h", tx, got);
   endtask

   initial begin
      logic [7:0]  got;
      logic [31:0] popped;
      logic [31:0] exp_pop;

      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
      vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF};
      vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
      vecs[3] = '{1'b1, 8'h5A, 8'h00, 8'h5A};
      vecs[4] = '{1'b0, 8'h00, 8'h81, 8'hFF};
      vecs[5] = '{1'b1, 8'h80, 8'h7E, 8'h80};

      repeat (4) @(negedge clk);
      check("reset_outputs", {28'h0, iomem_ready, |iomem_rdata, spi_miso, spi_miso_oe}, 32'h0);
      reset = 1'b0;
      rd_check("reset_status", 2'd1, 32'h04);
      rd_check("reset_count", 2'd2, 32'h0);
      rd_check("reg3", 2'd3, 32'h0);
      pop_check("empty_read");

      // Table-driven single-byte sessions
      for (int v = 0; v < 6; v++) begin
         bus_wr(2'd1, 32'h70);
         if (vecs[v].load) begin
            bus_wr(2'd0, {24'h0, vecs[v].hold});
         end
         miso_q.push_back(vecs[v].miso);
         cs_on();
         xfer(vecs[v].mosi);
         cs_off();
         pop_check("vec_data");
         rd_check("vec_status", 2'd1, 32'h24);
      end

      // Two bytes with nothing loaded: idle bytes, UNR set then cleared
      bus_wr(2'd1, 32'h70);
      rd_check("clr_status", 2'd1, 32'h04);
      miso_q.push_back(8'hFF);
      miso_q.push_back(8'hFF);
      cs_on();
      xfer(8'h12);
      xfer(8'h34);
      cs_off();
      rd_check("unr_status", 2'd1, 32'h25);
      bus_wr(2'd1, 32'h20);
      rd_check("unr_cleared", 2'd1, 32'h05);
      pop_check("unr_data0");
      pop_check("unr_data1");

      // Second write into a full HOLD is dropped and raises TXO
      bus_wr(2'd1, 32'h70);
      bus_wr(2'd0, 32'h11);
      bus_wr(2'd0, 32'h22);
      rd_check("txo_status", 2'd1, 32'h40);
      bus_wr(2'd1, 32'h40);
      rd_check("txo_cleared", 2'd1, 32'h00);
      miso_q.push_back(8'h11);
      cs_on();
      xfer(8'h99);
      cs_off();
      pop_check("txo_data");

      // Overrun: five bytes into a four-entry FIFO
      bus_wr(2'd1, 32'h70);
      for (int b = 1; b <= 5; b++) miso_q.push_back(8'hFF);
      cs_on();
      for (int b = 1; b <= 5; b++) xfer(8'(b));
      cs_off();
      rd_check("ovr_count", 2'd2, 32'd4);
      rd_check("ovr_status", 2'd1, 32'h37);
      for (int b = 0; b < 4; b++) pop_check("ovr_data");
      pop_check("ovr_empty_read");

      // Deselect after five bits: nothing pushed, next byte intact
      bus_wr(2'd1, 32'h70);
      cs_on();
      spi_byte(8'hF0, 5, -1, got, popped);
      cs_off();
      check("partial_oe", {31'h0, spi_miso_oe}, 32'h0);
      rd_check("partial_count", 2'd2, 32'd0);
      miso_q.push_back(8'hFF);
      cs_on();
      xfer(8'h81);
      cs_off();
      pop_check("after_partial");

      // Pop on the same clk as the push into a full FIFO
      bus_wr(2'd1, 32'h70);
      for (int b = 0; b < 5; b++) miso_q.push_back(8'hFF);
      cs_on();
      xfer(8'h11);
      xfer(8'h22);
      xfer(8'h33);
      xfer(8'h44);
      spi_byte(8'h55, 8, 0, got, popped);
      check("race_miso", {24'h0, got}, {24'h0, miso_q.pop_front()});
      exp_pop = rx_q.pop_front();
      check("race_pop", popped, exp_pop);
      rx_q.push_back({23'h0, 1'b1, 8'h55});
      cs_off();
      rd_check("race_count", 2'd2, 32'd4);
      rd_check("race_status", 2'd1, 32'h27);
      for (int b = 0; b < 4; b++) pop_check("race_data");

      // Asynchronous reset in the middle of a byte
      bus_wr(2'd1, 32'h70);
      bus_wr(2'd0, 32'hA5);
      miso_q.push_back(8'hA5);
      cs_on();
      xfer(8'h77);
      cs_off();
      bus_wr(2'd0, 32'hA5);
      cs_on();
      spi_byte(8'hC3, 2, -1, got, popped);
      repeat (8) @(negedge clk);
      check("pre_reset_pins", {30'h0, spi_miso, spi_miso_oe}, 32'h3);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_pins", {30'h0, spi_miso, spi_miso_oe}, 32'h0);
      check("async_reset_bus", {iomem_rdata[30:0], iomem_ready}, 32'h0);
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rx_q.delete();
      miso_q.delete();
      mdl_cnt = 0;
      rd_check("post_reset_count", 2'd2, 32'd0);
      miso_q.push_back(8'hFF);
      cs_on();
      xfer(8'h5A);
      cs_off();
      pop_check("post_reset_data");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
